ir_fetch_ctrl: RTL



---
 rtl/ir_pkg.sv | 11 +
 rtl/ir_skid_reg.sv | 31 +++
 rtl/ir_fetch_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared widths, reset PC and fetch state encoding for the instruction-word stream
package ir_pkg;
    localparam int IR_DATA_W = 16;
    localparam int IR_ADDR_W = 16;
    localparam logic [IR_ADDR_W-1:0] IR_RESET_PC = '0;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;
endpackage

// File: rtl/ir_skid_reg.sv
// ir_skid_reg: one-entry holding register with capture/drain/flush (flush > capture > drain); ports clk, rst_n, capture_i, drain_i, flush_i, d_i -> q_o, valid_o
module ir_skid_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture_i,
    input  logic         drain_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         valid_o
);
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    always_comb begin
        data_d  = (capture_i && !flush_i) ? d_i : data_q;
        valid_d = flush_i ? 1'b0 : capture_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign q_o     = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/ir_fetch_ctrl.sv
// ir_fetch_ctrl: sequential instruction fetcher feeding one word per cycle, with stall skid and jump flush; ports clk, rst (async active-low), stall, i_jump, i_jump_addr, mem_rdata -> mem_addr, mem_rd_en, o_data, o_valid
module ir_fetch_ctrl
    import ir_pkg::*;
#(
    parameter int                DATA_W   = IR_DATA_W,
    parameter int                ADDR_W   = IR_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IR_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pending_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              skid_capture, skid_drain;
    // a word still in flight when stall hits is parked in the skid; the skid gates new reads
    // so at most one word is ever outstanding
    assign mem_addr     = pc_q;
    assign mem_rd_en    = (state_q == ST_RUN) && !stall && !i_jump && !skid_valid;
    assign skid_capture = stall && !i_jump && pending_q;
    assign skid_drain   = !stall && !i_jump && skid_valid;
    ir_skid_reg #(.W(DATA_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .capture_i (skid_capture),
        .drain_i   (skid_drain),
        .flush_i   (i_jump),
        .d_i       (mem_rdata),
        .q_o       (skid_data),
        .valid_o   (skid_valid)
    );
    always_comb begin
        state_d = (state_q == ST_RUN && i_jump) ? ST_FLUSH : ST_RUN;
        pc_d    = i_jump ? i_jump_addr : mem_rd_en ? pc_q + ADDR_W'(1) : pc_q;
        valid_d = i_jump ? 1'b0 : stall ? valid_q : (skid_valid || pending_q);
        data_d  = (i_jump || stall) ? data_q : skid_valid ? skid_data : pending_q ? mem_rdata : data_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= mem_rd_en;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end
    assign o_data  = data_q;
    assign o_valid = valid_q;
endmodule
